// File: rtl/game_flow_ctrl_pkg.sv
// Shared types and the end-of-game decision for the penalty game flow controller.
package game_flow_ctrl_pkg;

  typedef enum logic [2:0] {
    StStart    = 3'd0,
    StWaitPeer = 3'd1,
    StKeeper   = 3'd2,
    StShooter  = 3'd3,
    StWinner   = 3'd4,
    StLooser   = 3'd5,
    StDraw     = 3'd6
  } g_state_e;

  typedef enum logic {
    ModeMulti = 1'b0,
    ModeSolo  = 1'b1
  } g_mode_e;

  typedef enum logic [1:0] {
    ResNone,
    ResWin,
    ResLose,
    ResDraw
  } g_result_e;

  // Evaluated on the already-updated counts of the shot being resolved.
  function automatic g_result_e decide_result(
    input g_mode_e     mode,
    input int unsigned rounds_done,
    input int unsigned own,
    input int unsigned opp,
    input int unsigned rounds,
    input int unsigned win_saves,
    input int unsigned sd_pairs
  );
    g_result_e res;
    res = ResNone;
    if (mode == ModeSolo) begin
      if (rounds_done >= rounds) begin
        res = (own >= win_saves) ? ResWin : ResLose;
      end
    end else if ((rounds_done % 2) == 0 && rounds_done >= 2 * rounds) begin
      if (own > opp) begin
        res = ResWin;
      end else if (own < opp) begin
        res = ResLose;
      end else if (rounds_done >= 2 * (rounds + sd_pairs)) begin
        res = ResDraw;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_peer_timeout.sv
// Handshake watchdog: reloads while idle, counts down while waiting for the peer.
module game_flow_ctrl_peer_timeout #(
  parameter int unsigned PeerTmo = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic tmo_o
);

  localparam int unsigned TmoW = $clog2(PeerTmo + 1);
  localparam logic [TmoW-1:0] LoadVal = TmoW'(PeerTmo - 1);

  logic [TmoW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i) begin
      cnt_d = LoadVal;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the PeerTmo-th cycle spent waiting.
  assign tmo_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Penalty game next-state controller: SOLO keeper run or MULTI alternating-role match.
module game_flow_ctrl
  import game_flow_ctrl_pkg::*;
#(
  parameter int unsigned Rounds   = 5,
  parameter int unsigned WinSaves = 3,
  parameter int unsigned SdPairs  = 3,
  parameter int unsigned CntW     = 4,
  parameter int unsigned PeerTmo  = 100_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            left_clicked_i,
  input  logic            solo_enable_i,
  input  logic            is_host_i,
  input  logic            peer_ready_i,
  input  logic            round_done_i,
  input  logic            goal_i,
  output logic [2:0]      game_state_o,
  output logic            game_mode_o,
  output logic [CntW-1:0] round_cnt_o,
  output logic [CntW-1:0] score_own_o,
  output logic [CntW-1:0] score_opp_o,
  output logic            state_chg_o
);

  g_state_e        state_q, state_d;
  g_mode_e         mode_q, mode_d;
  logic [CntW-1:0] rc_q, rc_d, own_q, own_d, opp_q, opp_d;
  logic [CntW-1:0] rc_inc, own_upd, opp_upd;
  logic            chg_q;
  logic            waiting, tmo;
  g_result_e       res;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign waiting = (state_q == StWaitPeer);

  game_flow_ctrl_peer_timeout #(
    .PeerTmo(PeerTmo)
  ) u_peer_timeout (
    .clk  (clk),
    .rst  (rst),
    .run_i(waiting),
    .tmo_o(tmo)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rc_d    = rc_q;
    own_d   = own_q;
    opp_d   = opp_q;
    rc_inc  = sat_inc(rc_q);
    own_upd = own_q;
    opp_upd = opp_q;

    // SOLO counts saves; MULTI credits the goal to whoever is shooting.
    if (mode_q == ModeSolo) begin
      if (!goal_i) own_upd = sat_inc(own_q);
    end else if (goal_i) begin
      if (state_q == StShooter) own_upd = sat_inc(own_q);
      else                      opp_upd = sat_inc(opp_q);
    end

    res = decide_result(mode_q, 32'(rc_inc), 32'(own_upd), 32'(opp_upd),
                        Rounds, WinSaves, SdPairs);

    case (state_q)
      StStart: begin
        mode_d = solo_enable_i ? ModeSolo : ModeMulti;
        if (left_clicked_i) state_d = solo_enable_i ? StKeeper : StWaitPeer;
      end
      StWaitPeer: begin
        if (mode_q == ModeSolo)  state_d = StStart;
        else if (peer_ready_i)   state_d = is_host_i ? StShooter : StKeeper;
        else if (tmo)            state_d = StStart;
      end
      StKeeper, StShooter: begin
        if (mode_q == ModeSolo && state_q == StShooter) begin
          state_d = StStart;
        end else if (round_done_i) begin
          rc_d  = rc_inc;
          own_d = own_upd;
          opp_d = opp_upd;
          case (res)
            ResWin:  state_d = StWinner;
            ResLose: state_d = StLooser;
            ResDraw: state_d = StDraw;
            default: begin
              if (mode_q == ModeSolo)       state_d = StKeeper;
              else if (state_q == StKeeper) state_d = StShooter;
              else                          state_d = StKeeper;
            end
          endcase
        end
      end
      StWinner, StLooser, StDraw: begin
        if (left_clicked_i) state_d = StStart;
      end
      default: state_d = StStart;
    endcase

    if (state_d == StStart) begin
      rc_d  = '0;
      own_d = '0;
      opp_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StStart;
      mode_q  <= ModeMulti;
      rc_q    <= '0;
      own_q   <= '0;
      opp_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rc_q    <= rc_d;
      own_q   <= own_d;
      opp_q   <= opp_d;
      chg_q   <= (state_d != state_q);
    end
  end

  assign game_state_o = state_q;
  assign game_mode_o  = mode_q;
  assign round_cnt_o  = rc_q;
  assign score_own_o  = own_q;
  assign score_opp_o  = opp_q;
  assign state_chg_o  = chg_q;

endmodule
